// File: rtl/bcd_display_scan_if.sv
// Display-side bundle of the BCD display scanner: converter result and
// controls in, conversion start and common-anode drive out.
interface bcd_display_scan_if;
    logic [15:0] bcd;
    logic [3:0]  dp_sel;
    logic        hold;
    logic        conv_start;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output bcd,
        output dp_sel,
        output hold,
        input  conv_start,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  bcd,
        input  dp_sel,
        input  hold,
        output conv_start,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Four-digit common-anode seven-segment scanner with periodic BCD conversion and latch.
// Optional leading-zero blanking on digits 1..3 when BCD_DISPLAY_LZB_EN is defined.
module bcd_display_scan #(
    parameter int SCAN_DIV   = 100000,
    parameter int UPDATE_DIV = 10000000,
    parameter int CONV_WAIT  = 40
) (
    input  logic              clk100Mhz,
    input  logic              rst,
    bcd_display_scan_if.slave dsp_if
);
    localparam int PS_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int UP_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam int CW_W = (CONV_WAIT  > 1) ? $clog2(CONV_WAIT)  : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
    localparam logic [UP_W-1:0] UP_LAST = UP_W'(UPDATE_DIV - 1);
    localparam logic [CW_W-1:0] CW_LAST = CW_W'(CONV_WAIT - 1);

    generate
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("bcd_display_scan: SCAN_DIV must be >= 2");
        end
        if (UPDATE_DIV < 1) begin : g_bad_update_div
            $error("bcd_display_scan: UPDATE_DIV must be >= 1");
        end
        if (CONV_WAIT < 1) begin : g_bad_conv_wait
            $error("bcd_display_scan: CONV_WAIT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t          state_q;
    logic [UP_W-1:0] up_cnt_q;
    logic [CW_W-1:0] cw_cnt_q;
    logic            conv_start_q;
    logic [15:0]     disp_bcd_q;
    logic [3:0]      disp_dp_q;

    logic [PS_W-1:0] ps_q, ps_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic [3:0]      cur_nib;
    logic            cur_blank;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib, input logic blank);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        if (blank) begin
            s = 7'h7F;
        end
        return s;
    endfunction

    // Update FSM: hold is only honoured in IDLE, so a started conversion always
    // runs through to its latch. The latch edge is the WAIT terminal count.
    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            up_cnt_q     <= '0;
            cw_cnt_q     <= '0;
            conv_start_q <= 1'b0;
            disp_bcd_q   <= '0;
            disp_dp_q    <= '0;
        end else begin
            conv_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (up_cnt_q == UP_LAST) begin
                        if (!dsp_if.hold) begin
                            state_q      <= S_START;
                            conv_start_q <= 1'b1;
                            up_cnt_q     <= '0;
                        end
                    end else begin
                        up_cnt_q <= up_cnt_q + UP_W'(1);
                    end
                end
                S_START: begin
                    state_q  <= S_WAIT;
                    cw_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (cw_cnt_q == CW_LAST) begin
                        state_q    <= S_LATCH;
                        disp_bcd_q <= dsp_if.bcd;
                        disp_dp_q  <= dsp_if.dp_sel;
                    end else begin
                        cw_cnt_q <= cw_cnt_q + CW_W'(1);
                    end
                end
                S_LATCH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cur_nib = disp_bcd_q[{idx_q, 2'b00} +: 4];

`ifdef BCD_DISPLAY_LZB_EN
    // A digit blanks only when it and every more-significant digit are zero.
    always_comb begin
        cur_blank = 1'b0;
        case (idx_q)
            2'd1:    cur_blank = (disp_bcd_q[15:4]  == 12'h000);
            2'd2:    cur_blank = (disp_bcd_q[15:8]  == 8'h00);
            2'd3:    cur_blank = (disp_bcd_q[15:12] == 4'h0);
            default: cur_blank = 1'b0;
        endcase
    end
`else
    assign cur_blank = 1'b0;
`endif

    // Outputs are decoded from the current index and latched value, so a latch
    // landing on a digit advance is already visible to the new digit.
    always_comb begin
        ps_d  = ps_q + PS_W'(1);
        idx_d = idx_q;
        if (ps_q == PS_LAST) begin
            ps_d  = '0;
            idx_d = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_encode(cur_nib, cur_blank);
        dp_d  = ~disp_dp_q[idx_q];
    end

    always_ff @(posedge clk100Mhz or posedge rst) begin
        if (rst) begin
            ps_q  <= '0;
            idx_q <= 2'd0;
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            ps_q  <= ps_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign dsp_if.conv_start = conv_start_q;
    assign dsp_if.an         = an_q;
    assign dsp_if.seg        = seg_q;
    assign dsp_if.dp         = dp_q;

endmodule
